// File: rtl/fetch_unit.sv
// PC generation and fetch sequencing in front of a synchronous-read instruction memory.
// Handles decode stalls (address replay), redirects (squash + refetch), halt and an accept counter.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [15:0]          redirect_pc,
    input  logic                 halt_req,
    output logic [15:0]          imem_pc,
    input  logic [31:0]          imem_instr,
    output logic [15:0]          if_pc,
    output logic [31:0]          if_instr,
    output logic                 if_valid,
    output logic                 misalign_err,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_r, pc_nxt;
    logic [15:0] req_pc_r, req_pc_nxt;
    logic        req_valid_r, req_valid_nxt;
    logic        misalign_nxt;
    logic [15:0] target;
    logic        accept;

    assign target = {redirect_pc[15:2], 2'b00};
    assign accept = if_valid & ~stall;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc_r         <= RESET_PC;
            req_pc_r     <= RESET_PC;
            req_valid_r  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state        <= state_nxt;
            pc_r         <= pc_nxt;
            req_pc_r     <= req_pc_nxt;
            req_valid_r  <= req_valid_nxt;
            misalign_err <= misalign_nxt;
            if (accept) begin
                fetch_count <= fetch_count + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_r;
        req_pc_nxt    = req_pc_r;
        req_valid_nxt = req_valid_r;
        misalign_nxt  = 1'b0;
        case (state)
            BOOT: begin
                state_nxt     = RUN;
                pc_nxt        = pc_r + 16'd4;
                req_pc_nxt    = pc_r;
                req_valid_nxt = 1'b1;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_nxt        = target + 16'd4;
                    req_pc_nxt    = target;
                    req_valid_nxt = 1'b1;
                    misalign_nxt  = |redirect_pc[1:0];
                end else if (stall) begin
                    // hold everything; imem_pc replays req_pc_r so the data stays put
                end else if (halt_req) begin
                    req_valid_nxt = 1'b0;
                    state_nxt     = HALT;
                end else begin
                    pc_nxt        = pc_r + 16'd4;
                    req_pc_nxt    = pc_r;
                    req_valid_nxt = 1'b1;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_nxt     = RUN;
                    pc_nxt        = target + 16'd4;
                    req_pc_nxt    = target;
                    req_valid_nxt = 1'b1;
                    misalign_nxt  = |redirect_pc[1:0];
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Reset is synchronous, so outputs are gated by rst_n to be quiet in the first reset cycle too.
    always_comb begin
        if_pc    = req_pc_r;
        if_instr = imem_instr;
        if_valid = rst_n & req_valid_r & ~redirect_valid;
        halted   = rst_n & (state == HALT);
        if (!rst_n) begin
            imem_pc = RESET_PC;
        end else if (redirect_valid) begin
            imem_pc = target;
        end else if (stall && state == RUN) begin
            imem_pc = req_pc_r;
        end else begin
            imem_pc = pc_r;
        end
    end

endmodule
